// File: rtl/dma_read_master.sv
// dma_read_master: Avalon-MM pipelined read master feeding the shared DMA FIFO.
// Latency: a read is issued the cycle after its reservation is granted; returned data reaches the FIFO 1 cycle after readdatavalid.
// Backpressure: iRM_waitrequest holds the current request stable; new reads need FF_usedw + pending < FIFO_DEPTH.
//
// Ports:
//   iClk, iReset_n          clock, asynchronous active-low reset
//   Start, Length,          level start (sampled in IDLE), byte length (Length[1:0] ignored),
//   RM_startaddress         word-aligned source byte address
//   oRM_read, oRM_readaddress, oRM_byteenable, iRM_waitrequest,
//   iRM_readdata, iRM_readdatavalid      Avalon-MM pipelined read master
//   FF_usedw, FF_writerequest, FF_data   downstream FIFO occupancy and push port
//   RM_done                 sticky transfer-complete flag, cleared by the next accepted Start
//   Abort                   only when RM_ABORT_EN is defined: stop issuing, drain and discard outstanding reads
module dma_read_master #(
   parameter int MAX_PENDING = 4,
   parameter int FIFO_DEPTH  = 256,
   parameter int USEDW_W     = 9
) (
   input  logic               iClk,
   input  logic               iReset_n,
   input  logic               Start,
   input  logic [31:0]        Length,
   input  logic [31:0]        RM_startaddress,
`ifdef RM_ABORT_EN
   input  logic               Abort,
`endif
   output logic               oRM_read,
   output logic [31:0]        oRM_readaddress,
   output logic [3:0]         oRM_byteenable,
   input  logic               iRM_waitrequest,
   input  logic [31:0]        iRM_readdata,
   input  logic               iRM_readdatavalid,
   input  logic [USEDW_W-1:0] FF_usedw,
   output logic               FF_writerequest,
   output logic [31:0]        FF_data,
   output logic               RM_done
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

   localparam logic [3:0]       LP_MAXP  = MAX_PENDING[3:0];
   localparam logic [USEDW_W:0] LP_DEPTH = FIFO_DEPTH[USEDW_W:0];

   state_t      r_state;
   logic [29:0] r_words_to_issue;
   logic [29:0] r_words_to_recv;
   logic [3:0]  r_pending;

   logic        w_start;
   logic        w_accept;
   logic        w_hold;
   logic        w_ret;
   logic        w_abort;
   logic        w_abort_exit;
   logic        w_push;
   logic        w_rd_nxt;
   logic [3:0]  w_pending_nxt;
   logic [29:0] w_wti_nxt;
   logic [29:0] w_wtr_nxt;
   logic        w_unused;

   // A read may only go out if the FIFO can absorb every word already in
   // flight plus this one; the sum is one bit wider than FF_usedw.
   function automatic logic f_can_issue(input logic [29:0]        wti,
                                        input logic [3:0]         pend,
                                        input logic [USEDW_W-1:0] usedw);
      logic [USEDW_W:0] resv;
      resv = {1'b0, usedw} + {{(USEDW_W-3){1'b0}}, pend};
      return (wti != 30'd0) && (pend < LP_MAXP) && (resv < LP_DEPTH);
   endfunction

   assign w_start       = Start & (Length[31:2] != 30'd0);
   assign w_accept      = oRM_read & ~iRM_waitrequest;
   assign w_hold        = oRM_read & iRM_waitrequest;
   // Data with nothing outstanding (e.g. stale beats after reset) is dropped.
   assign w_ret         = iRM_readdatavalid & (r_pending != 4'd0);
   assign w_push        = w_ret & ~w_abort;
   assign w_pending_nxt = r_pending + {3'd0, w_accept} - {3'd0, w_ret};
   assign w_wti_nxt     = r_words_to_issue - {29'd0, w_accept};
   assign w_wtr_nxt     = r_words_to_recv - {29'd0, w_ret};
   assign w_abort_exit  = w_abort & (w_pending_nxt == 4'd0) & ~w_hold;
   assign w_unused      = &{1'b0, Length[1:0]};

`ifdef RM_ABORT_EN
   logic r_abort;
   assign w_abort = (r_state != S_IDLE) & (r_abort | Abort);
`else
   assign w_abort = 1'b0;
`endif

   // Next-cycle request: a stalled request is held no matter what; otherwise
   // the reservation is re-evaluated against the post-edge counters.
   always_comb begin
      w_rd_nxt = 1'b0;
      if (r_state == S_IDLE)
         w_rd_nxt = w_start & f_can_issue(Length[31:2], 4'd0, FF_usedw);
      else if (w_hold)
         w_rd_nxt = 1'b1;
      else if (!w_abort)
         w_rd_nxt = f_can_issue(w_wti_nxt, w_pending_nxt, FF_usedw);
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         r_state          <= S_IDLE;
         r_words_to_issue <= 30'd0;
         r_words_to_recv  <= 30'd0;
         r_pending        <= 4'd0;
         oRM_read         <= 1'b0;
         oRM_readaddress  <= 32'd0;
         oRM_byteenable   <= 4'd0;
         FF_writerequest  <= 1'b0;
         FF_data          <= 32'd0;
         RM_done          <= 1'b0;
`ifdef RM_ABORT_EN
         r_abort          <= 1'b0;
`endif
      end else begin
         oRM_read        <= w_rd_nxt;
         oRM_byteenable  <= {4{w_rd_nxt}};
         FF_writerequest <= w_push;
         if (w_push)
            FF_data <= iRM_readdata;
`ifdef RM_ABORT_EN
         r_abort <= w_abort & ~w_abort_exit;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_words_to_issue <= Length[31:2];
                  r_words_to_recv  <= Length[31:2];
                  oRM_readaddress  <= RM_startaddress;
                  RM_done          <= 1'b0;
                  r_state          <= S_ISSUE;
               end
            end
            default: begin
               r_pending        <= w_pending_nxt;
               r_words_to_issue <= w_wti_nxt;
               r_words_to_recv  <= w_wtr_nxt;
               if (w_accept)
                  oRM_readaddress <= oRM_readaddress + 32'd4;
               if (w_abort) begin
                  if (w_abort_exit)
                     r_state <= S_IDLE;
               end else if (w_ret && (w_wtr_nxt == 30'd0)) begin
                  // Done rises on the same edge that pushes the last word.
                  RM_done <= 1'b1;
                  r_state <= S_IDLE;
               end else if ((r_state == S_ISSUE) && (w_wti_nxt == 30'd0)) begin
                  r_state <= S_DRAIN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_read_master.sv
`timescale 1ns/1ps
module tb_dma_read_master;
   localparam int MAXP  = 4;
   localparam int DEPTH = 256;
   localparam int UW    = 9;

   logic          iClk = 1'b0;
   logic          iReset_n;
   logic          Start;
   logic [31:0]   Length;
   logic [31:0]   RM_startaddress;
   logic          oRM_read;
   logic [31:0]   oRM_readaddress;
   logic [3:0]    oRM_byteenable;
   logic          iRM_waitrequest;
   logic [31:0]   iRM_readdata;
   logic          iRM_readdatavalid;
   logic [UW-1:0] FF_usedw;
   logic          FF_writerequest;
   logic [31:0]   FF_data;
   logic          RM_done;
   logic          abort_in;
`ifdef RM_ABORT_EN
   logic          Abort;
   assign abort_in = Abort;
`else
   assign abort_in = 1'b0;
`endif

   always #5 iClk = ~iClk;

   dma_read_master #(.MAX_PENDING(MAXP), .FIFO_DEPTH(DEPTH), .USEDW_W(UW)) dut (
      .iClk(iClk), .iReset_n(iReset_n), .Start(Start), .Length(Length),
      .RM_startaddress(RM_startaddress),
`ifdef RM_ABORT_EN
      .Abort(Abort),
`endif
      .oRM_read(oRM_read), .oRM_readaddress(oRM_readaddress), .oRM_byteenable(oRM_byteenable),
      .iRM_waitrequest(iRM_waitrequest), .iRM_readdata(iRM_readdata),
      .iRM_readdatavalid(iRM_readdatavalid), .FF_usedw(FF_usedw),
      .FF_writerequest(FF_writerequest), .FF_data(FF_data), .RM_done(RM_done));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory contents: a fixed function of the byte address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
   endfunction

   function automatic bit can_issue(input int wti, input int pend, input int usedw);
      return (wti > 0) && (pend < MAXP) && (usedw + pend < DEPTH);
   endfunction

   // ---------------- Avalon slave responder ----------------
   int          lat_min = 2, lat_max = 2, wait_pct = 0;
   int          stall_after = -1, stall_left = 0;
   bit          rdv_hold = 0, stray_en = 0;
   logic [31:0] rq_addr[$];
   longint      rq_due[$];
   logic [31:0] acc_log[$];
   longint      cyc = 0;
   int          max_out = 0, n1004 = 0;

   always @(posedge iClk) begin : p_slave
      bit          acc;
      logic [31:0] a;
      acc = iReset_n && oRM_read && !iRM_waitrequest;
      a   = oRM_readaddress;
      if (iReset_n && oRM_read && a == 32'h0000_1004) n1004++;
      #1;
      cyc++;
      if (!iReset_n) begin
         rq_addr.delete();
         rq_due.delete();
         acc = 0;
      end
      if (acc) begin
         rq_addr.push_back(a);
         rq_due.push_back(cyc - 1 + longint'($urandom_range(lat_min, lat_max)));
         acc_log.push_back(a);
      end
      if (rq_addr.size() > max_out) max_out = rq_addr.size();
      iRM_readdatavalid = 1'b0;
      iRM_readdata      = $urandom;
      if (rq_addr.size() > 0) begin
         if (!rdv_hold && cyc >= rq_due[0]) begin
            iRM_readdatavalid = 1'b1;
            iRM_readdata      = mem_word(rq_addr.pop_front());
            void'(rq_due.pop_front());
         end
      end else if (stray_en && $urandom_range(0, 2) == 0) begin
         iRM_readdatavalid = 1'b1;
      end
      if (stall_left > 0 && acc_log.size() == stall_after) begin
         iRM_waitrequest = 1'b1;
         stall_left--;
      end else begin
         iRM_waitrequest = (wait_pct > 0) && ($urandom_range(0, 99) < wait_pct);
      end
   end

   // ---------------- Reference model + per-cycle compare ----------------
   bit          m_busy = 0, m_done = 0, m_push = 0, m_rd_exp = 0, m_ab = 0;
   int          m_wti = 0, m_wtr = 0, m_pend = 0, m_push_cnt = 0, n_simul = 0;
   logic [31:0] m_addr = 0, m_pdat = 0;
   logic [31:0] m_exp_q[$];
   logic [31:0] push_log[$];

   always @(negedge iClk) begin : p_model
      bit acc, ret, hold, abt;
      if (!iReset_n) begin
         chk("rst_read", 32'(oRM_read), 32'd0);
         chk("rst_addr", oRM_readaddress, 32'd0);
         chk("rst_be", 32'(oRM_byteenable), 32'd0);
         chk("rst_push", 32'(FF_writerequest), 32'd0);
         chk("rst_data", FF_data, 32'd0);
         chk("rst_done", 32'(RM_done), 32'd0);
         m_busy = 0; m_done = 0; m_push = 0; m_rd_exp = 0; m_ab = 0;
         m_wti = 0; m_wtr = 0; m_pend = 0;
         m_exp_q.delete();
      end else begin
         chk("rd_req", 32'(oRM_read), 32'(m_rd_exp));
         if (oRM_read) begin
            chk("rd_addr", oRM_readaddress, m_addr);
            chk("rd_be", 32'(oRM_byteenable), 32'hF);
         end
         chk("push", 32'(FF_writerequest), 32'(m_push));
         if (m_push) chk("push_data", FF_data, m_pdat);
         chk("done", 32'(RM_done), 32'(m_done));
         if (FF_writerequest) begin
            m_push_cnt++;
            push_log.push_back(FF_data);
         end
         if (rq_addr.size() > MAXP) chk("outstanding", 32'(rq_addr.size()), 32'(MAXP));

         acc  = oRM_read && !iRM_waitrequest;
         hold = oRM_read && iRM_waitrequest;
         ret  = iRM_readdatavalid && (m_pend > 0);
         abt  = m_busy && (m_ab || abort_in);
         if (acc && ret) n_simul++;
         m_push = 0;
         if (!m_busy) begin
            if (Start && Length[31:2] != 30'd0) begin
               m_busy = 1; m_done = 0;
               m_wti = int'(Length[31:2]); m_wtr = m_wti; m_pend = 0;
               m_addr = RM_startaddress;
               m_rd_exp = can_issue(m_wti, 0, int'(FF_usedw));
            end else begin
               m_rd_exp = 0;
            end
         end else begin
            if (acc) begin
               m_exp_q.push_back(mem_word(m_addr));
               m_addr += 32'd4; m_wti--; m_pend++;
            end
            if (ret) begin
               m_pend--; m_wtr--;
               if (m_exp_q.size() > 0) m_pdat = m_exp_q.pop_front();
               m_push = !abt;
            end
            if (abt) begin
               m_ab = 1;
               if (m_pend == 0 && !hold) begin m_busy = 0; m_ab = 0; end
            end else if (ret && m_wtr == 0) begin
               m_busy = 0; m_done = 1;
            end
            m_rd_exp = hold || (m_busy && !abt && can_issue(m_wti, m_pend, int'(FF_usedw)));
         end
      end
   end

   // ---------------- Directed + random stimulus ----------------
   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic start_xfer(input logic [31:0] a, input logic [31:0] len);
      RM_startaddress = a; Length = len; Start = 1'b1;
      step();
      Start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n = 0;
      while ((m_busy || rq_addr.size() != 0) && n < budget) begin step(); n++; end
      if (m_busy || rq_addr.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, budget);
      end
      step();
   endtask

   task automatic wait_acc(input int cnt, input int budget, input string nm);
      int n = 0;
      while (acc_log.size() < cnt && n < budget) begin step(); n++; end
      if (acc_log.size() < cnt) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: %0d accepts, required %0d", nm, acc_log.size(), cnt);
      end
   endtask

   task automatic new_test();
      acc_log.delete(); push_log.delete(); m_push_cnt = 0; max_out = 0;
   endtask

   initial begin
      logic [31:0] a, len;
      iReset_n = 0; Start = 0; Length = 0; RM_startaddress = 0; FF_usedw = 0;
      iRM_waitrequest = 0; iRM_readdata = 0; iRM_readdatavalid = 0;
`ifdef RM_ABORT_EN
      Abort = 0;
`endif
      repeat (3) step();
      iReset_n = 1;
      step();

      // Basic 4-word transfer, latency 2
      new_test(); n_simul = 0;
      start_xfer(32'h0000_1000, 32'd16);
      wait_idle(200, "basic");
      chk("basic_nreads", 32'(acc_log.size()), 32'd4);
      for (int i = 0; i < acc_log.size() && i < 4; i++)
         chk("basic_addr", acc_log[i], 32'h0000_1000 + 32'(4 * i));
      chk("basic_pushes", 32'(m_push_cnt), 32'd4);
      if (push_log.size() > 0) chk("basic_first_word", push_log[0], 32'h4A5A_D3C3);
      chk("basic_done", 32'(RM_done), 32'd1);
      chk("basic_simul_seen", 32'(n_simul > 0), 32'd1);

      // Pending limit: returns withheld
      new_test(); rdv_hold = 1;
      start_xfer(32'h0000_2000, 32'd64);
      repeat (20) step();
      chk("plim_accepts", 32'(acc_log.size()), 32'd4);
      chk("plim_read_low", 32'(oRM_read), 32'd0);
      rdv_hold = 0;
      wait_idle(400, "plim");
      chk("plim_pushes", 32'(m_push_cnt), 32'd16);
      chk("plim_max_out", 32'(max_out), 32'd4);

      // FIFO reservation: only 2 slots free
      new_test(); rdv_hold = 1; FF_usedw = 9'd254;
      start_xfer(32'h0000_3000, 32'd32);
      repeat (20) step();
      chk("fifo_accepts", 32'(acc_log.size()), 32'd2);
      chk("fifo_outstanding", 32'(max_out), 32'd2);
      FF_usedw = 9'd0; rdv_hold = 0;
      wait_idle(400, "fifo");
      chk("fifo_total_reads", 32'(acc_log.size()), 32'd8);
      chk("fifo_pushes", 32'(m_push_cnt), 32'd8);

      // Waitrequest on the 2nd read for 3 cycles
      new_test(); n1004 = 0; stall_after = 1; stall_left = 3;
      start_xfer(32'h0000_1000, 32'd16);
      wait_idle(200, "wait");
      stall_after = -1;
      chk("wait_hold_cycles", 32'(n1004), 32'd4);
      chk("wait_nreads", 32'(acc_log.size()), 32'd4);
      if (acc_log.size() > 1) chk("wait_second_addr", acc_log[1], 32'h0000_1004);
      chk("wait_pushes", 32'(m_push_cnt), 32'd4);

      // Length < 4: no transfer, done flag untouched
      new_test();
      start_xfer(32'h0000_4000, 32'd3);
      repeat (8) step();
      chk("short_nreads", 32'(acc_log.size()), 32'd0);
      chk("short_done_kept", 32'(RM_done), 32'd1);

      // Address wrap
      new_test();
      start_xfer(32'hFFFF_FFFC, 32'd8);
      wait_idle(200, "wrap");
      chk("wrap_nreads", 32'(acc_log.size()), 32'd2);
      if (acc_log.size() > 1) chk("wrap_second_addr", acc_log[1], 32'h0000_0000);

      // Reset mid-transfer, then stray readdatavalid
      new_test(); lat_min = 3; lat_max = 3;
      start_xfer(32'h0000_5000, 32'd32);
      wait_acc(2, 50, "rstmid");
      iReset_n = 0;
      step(); step();
      chk("rstmid_read", 32'(oRM_read), 32'd0);
      chk("rstmid_push", 32'(FF_writerequest), 32'd0);
      iReset_n = 1; m_push_cnt = 0; stray_en = 1;
      repeat (12) step();
      stray_en = 0;
      chk("rstmid_stray_pushes", 32'(m_push_cnt), 32'd0);
      chk("rstmid_done", 32'(RM_done), 32'd0);

`ifdef RM_ABORT_EN
      // Abort after 3 accepts: returns discarded, done stays 0
      new_test(); lat_min = 2; lat_max = 2; rdv_hold = 1;
      start_xfer(32'h0000_6000, 32'd12);
      wait_acc(3, 50, "abort");
      Abort = 1; rdv_hold = 0;
      wait_idle(200, "abort");
      Abort = 0;
      chk("abort_nreads", 32'(acc_log.size()), 32'd3);
      chk("abort_pushes", 32'(m_push_cnt), 32'd0);
      chk("abort_done", 32'(RM_done), 32'd0);
`endif

      // Randomized transfers
      for (int t = 0; t < 8; t++) begin
         int n;
         new_test();
         lat_min = 1; lat_max = $urandom_range(1, 6); wait_pct = $urandom_range(0, 40);
         a = $urandom; a[1:0] = 2'b00;
         if (t == 3) a = 32'hFFFF_FFE0;
         len = ($urandom_range(1, 48) << 2) | $urandom_range(0, 3);
         start_xfer(a, len);
         n = 0;
         while (m_busy && n < 3000) begin
            FF_usedw = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(250, 256)) : 9'($urandom_range(0, 255));
            if (m_wtr > 2 && $urandom_range(0, 7) == 0) begin Start = 1; Length = $urandom; end
            else Start = 0;
            step(); n++;
         end
         Start = 0; FF_usedw = 0;
         wait_idle(500, "rand");
         chk("rand_pushes", 32'(m_push_cnt), len >> 2);
         chk("rand_done", 32'(RM_done), 32'd1);
      end
      wait_pct = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
